// File: rtl/mem_responder.sv
// Shared single-array memory responder: burst instruction read port plus single-word data read/write port.
// Define MEM_RESPONDER_STALL_EN to hold each command off for P_STALL_CYCLES cycles before acceptance.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 8
`endif
`ifndef WORD_BITS
`define WORD_BITS 32
`endif

module mem_responder #(
  parameter int unsigned P_ADDR_BITS    = `MEM_ADDR_BITS,
  parameter int unsigned P_MAX_BURST    = 8,
  parameter int unsigned P_STALL_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_inst_read,
  input  logic [`MEM_ADDR_BITS-1:0]  i_inst_addr,
  input  logic [`WORD_BITS-1:0]      i_inst_burstcount,
  output logic                       o_inst_waitrequest,
  output logic [`WORD_BITS-1:0]      o_inst_readdata,
  output logic                       o_inst_readdatavalid,
  input  logic                       i_data_read,
  input  logic                       i_data_write,
  input  logic [`MEM_ADDR_BITS-1:0]  i_data_addr,
  input  logic [`WORD_BITS-1:0]      i_data_writedata,
  output logic                       o_data_waitrequest,
  output logic [`WORD_BITS-1:0]      o_data_readdata,
  output logic                       o_data_readdatavalid
);

  localparam int unsigned WORD_W = `WORD_BITS;
  localparam int unsigned DEPTH  = 2 ** P_ADDR_BITS;
  localparam int unsigned CNT_W  = (P_MAX_BURST > 1) ? $clog2(P_MAX_BURST) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] IBURST = 1'b1;

  logic [WORD_W-1:0]      mem [DEPTH];
  logic [0:0]             state, state_n;
  logic [CNT_W-1:0]       burst_rem, burst_rem_n;
  logic [P_ADDR_BITS-1:0] burst_ptr, burst_ptr_n;
  logic                   inst_valid_n, data_valid_n;
  logic [WORD_W-1:0]      inst_data_n, data_data_n;
  logic [WORD_W-1:0]      eff_len_c;
  logic                   data_req_c, stall_c;
  logic                   inst_acc_c, data_rd_acc_c, data_wr_acc_c;
  logic [P_ADDR_BITS-1:0] inst_addr_c, data_addr_c;

  assign inst_addr_c = P_ADDR_BITS'(i_inst_addr);
  assign data_addr_c = P_ADDR_BITS'(i_data_addr);
  assign data_req_c  = i_data_read | i_data_write;

  // Data port wins over the instruction port in a shared IDLE cycle
  assign o_data_waitrequest = (state != IDLE) | stall_c;
  assign o_inst_waitrequest = (state != IDLE) | data_req_c | stall_c;

  assign data_wr_acc_c = i_data_write & ~o_data_waitrequest;
  assign data_rd_acc_c = i_data_read & ~i_data_write & ~o_data_waitrequest;
  assign inst_acc_c    = i_inst_read & ~o_inst_waitrequest;

`ifdef MEM_RESPONDER_STALL_EN
  localparam int unsigned STALL_W = (P_STALL_CYCLES > 0) ? $clog2(P_STALL_CYCLES + 1) : 1;

  logic [STALL_W-1:0] stall_cnt, stall_cnt_n;
  logic               pending_c;

  assign pending_c = (state == IDLE) & (data_req_c | i_inst_read);
  assign stall_c   = pending_c & (32'(stall_cnt) < P_STALL_CYCLES);

  // Counts wait cycles of the pending command; restarts after every acceptance
  always_comb begin
    stall_cnt_n = stall_cnt;
    if (inst_acc_c || data_rd_acc_c || data_wr_acc_c) begin
      stall_cnt_n = '0;
    end else if (stall_c) begin
      stall_cnt_n = stall_cnt + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt_n;
    end
  end
`else
  logic unused_stall_cfg;
  assign unused_stall_cfg = ^P_STALL_CYCLES;
  assign stall_c          = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_n      = state;
    burst_rem_n  = burst_rem;
    burst_ptr_n  = burst_ptr;
    inst_valid_n = 1'b0;
    inst_data_n  = o_inst_readdata;
    data_valid_n = 1'b0;
    data_data_n  = o_data_readdata;

    eff_len_c = i_inst_burstcount;
    if (i_inst_burstcount == '0) begin
      eff_len_c = WORD_W'(1);
    end else if (i_inst_burstcount > WORD_W'(P_MAX_BURST)) begin
      eff_len_c = WORD_W'(P_MAX_BURST);
    end

    case (state)
      IDLE: begin
        if (data_rd_acc_c) begin
          data_valid_n = 1'b1;
          data_data_n  = mem[data_addr_c];
        end
        // First beat leaves on the acceptance edge; burst_rem counts the beats still owed
        if (inst_acc_c) begin
          state_n      = IBURST;
          inst_valid_n = 1'b1;
          inst_data_n  = mem[inst_addr_c];
          burst_rem_n  = CNT_W'(eff_len_c - WORD_W'(1));
          burst_ptr_n  = inst_addr_c + P_ADDR_BITS'(1);
        end
      end
      IBURST: begin
        if (burst_rem != '0) begin
          inst_valid_n = 1'b1;
          inst_data_n  = mem[burst_ptr];
          burst_rem_n  = burst_rem - CNT_W'(1);
          burst_ptr_n  = burst_ptr + P_ADDR_BITS'(1);
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      burst_rem            <= '0;
      burst_ptr            <= '0;
      o_inst_readdatavalid <= 1'b0;
      o_inst_readdata      <= '0;
      o_data_readdatavalid <= 1'b0;
      o_data_readdata      <= '0;
    end else begin
      state                <= state_n;
      burst_rem            <= burst_rem_n;
      burst_ptr            <= burst_ptr_n;
      o_inst_readdatavalid <= inst_valid_n;
      o_inst_readdata      <= inst_data_n;
      o_data_readdatavalid <= data_valid_n;
      o_data_readdata      <= data_data_n;
    end
  end

  // Memory contents survive reset
  always_ff @(posedge clk) begin
    if (data_wr_acc_c) begin
      mem[data_addr_c] <= i_data_writedata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed stimulus pushes expected beats, a negedge monitor pops and compares.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 8
`endif
`ifndef WORD_BITS
`define WORD_BITS 32
`endif

module tb_mem_responder;

  localparam int unsigned A = `MEM_ADDR_BITS;
  localparam int unsigned W = `WORD_BITS;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         i_inst_read = 1'b0;
  logic [A-1:0] i_inst_addr = '0;
  logic [W-1:0] i_inst_burstcount = '0;
  logic         o_inst_waitrequest;
  logic [W-1:0] o_inst_readdata;
  logic         o_inst_readdatavalid;
  logic         i_data_read = 1'b0;
  logic         i_data_write = 1'b0;
  logic [A-1:0] i_data_addr = '0;
  logic [W-1:0] i_data_writedata = '0;
  logic         o_data_waitrequest;
  logic [W-1:0] o_data_readdata;
  logic         o_data_readdatavalid;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] inst_q[$];
  logic [W-1:0] data_q[$];

  mem_responder dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_inst_read          (i_inst_read),
    .i_inst_addr          (i_inst_addr),
    .i_inst_burstcount    (i_inst_burstcount),
    .o_inst_waitrequest   (o_inst_waitrequest),
    .o_inst_readdata      (o_inst_readdata),
    .o_inst_readdatavalid (o_inst_readdatavalid),
    .i_data_read          (i_data_read),
    .i_data_write         (i_data_write),
    .i_data_addr          (i_data_addr),
    .i_data_writedata     (i_data_writedata),
    .o_data_waitrequest   (o_data_waitrequest),
    .o_data_readdata      (o_data_readdata),
    .o_data_readdatavalid (o_data_readdatavalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Monitor: every presented beat must match the head of its scoreboard queue
  always @(negedge clk) begin
    if (rst) begin
      if (o_data_readdatavalid) begin
        if (data_q.size() == 0) flag_fail("data_unexpected_beat");
        else check("data_beat", o_data_readdata, data_q.pop_front());
      end
      if (o_inst_readdatavalid) begin
        if (inst_q.size() == 0) flag_fail("inst_unexpected_beat");
        else check("inst_beat", o_inst_readdata, inst_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic data_wr(input logic [A-1:0] a, input logic [W-1:0] d);
    bit done;
    done = 1'b0;
    i_data_write = 1'b1; i_data_addr = a; i_data_writedata = d;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      done = !o_data_waitrequest;
      cyc();
    end
    i_data_write = 1'b0;
    if (!done) flag_fail("data_wr_timeout");
  endtask

  task automatic data_rd(input logic [A-1:0] a, input logic [W-1:0] exp, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    i_data_read = 1'b1; i_data_addr = a;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      if (o_data_waitrequest) waits++;
      else begin
        done = 1'b1;
        data_q.push_back(exp);
      end
      cyc();
    end
    i_data_read = 1'b0;
    if (!done) flag_fail("data_rd_timeout");
    else check("data_rd_latency", W'(o_data_readdatavalid), W'(1));
  endtask

  task automatic inst_rd(input logic [A-1:0] a, input logic [W-1:0] cnt);
    bit done;
    done = 1'b0;
    i_inst_read = 1'b1; i_inst_addr = a; i_inst_burstcount = cnt;
    for (int n = 0; n < 20 && !done; n++) begin
      #1;
      done = !o_inst_waitrequest;
      cyc();
    end
    i_inst_read = 1'b0;
    if (!done) flag_fail("inst_rd_timeout");
  endtask

  // Counts cycles the burst keeps the instruction port busy
  task automatic burst_len(input string name, input int exp);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 30 && !done; k++) begin
      #1;
      if (o_inst_waitrequest) n++;
      else done = 1'b1;
      cyc();
    end
    check(name, W'(n), W'(exp));
  endtask

  initial begin
    int w;
    #12;
    check("rst_inst_valid", W'(o_inst_readdatavalid), W'(0));
    check("rst_data_valid", W'(o_data_readdatavalid), W'(0));
    check("rst_inst_rdata", o_inst_readdata, W'(0));
    check("rst_data_rdata", o_data_readdata, W'(0));
    check("rst_inst_wait", W'(o_inst_waitrequest), W'(0));
    check("rst_data_wait", W'(o_data_waitrequest), W'(0));
    @(negedge clk);
    rst = 1'b1;
    cyc();

    data_wr(A'(9), W'(32'h55));
    data_wr(A'(5), W'(32'hDEADBEEF));

`ifdef MEM_RESPONDER_STALL_EN
    i_data_read = 1'b1; i_data_addr = A'(5);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_data_wait", W'(o_data_waitrequest), (k < 2) ? W'(1) : W'(0));
      if (k == 2) data_q.push_back(W'(32'hDEADBEEF));
      cyc();
    end
    i_data_read = 1'b0;
    check("stall_data_latency", W'(o_data_readdatavalid), W'(1));
    cyc();
`else
    data_rd(A'(5), W'(32'hDEADBEEF), w);
    check("raw_no_wait", W'(w), W'(0));

    data_rd(A'(9), W'(32'h55), w);
    data_rd(A'(5), W'(32'hDEADBEEF), w);

    i_data_write = 1'b1; i_data_read = 1'b1; i_data_addr = A'(6); i_data_writedata = W'(32'h66);
    #1;
    check("rw_accept", W'(o_data_waitrequest), W'(0));
    cyc();
    i_data_write = 1'b0; i_data_read = 1'b0;
    check("rw_read_ignored", W'(o_data_readdatavalid), W'(0));
    data_rd(A'(6), W'(32'h66), w);

    for (int i = 0; i < 4; i++) data_wr(A'(i), W'(32'h10 + i));
    for (int i = 0; i < 4; i++) inst_q.push_back(W'(32'h10 + i));
    inst_rd(A'(0), W'(4));
    for (int k = 0; k < 4; k++) begin
      #1;
      check("burst4_wait", W'(o_inst_waitrequest), W'(1));
      check("burst4_valid", W'(o_inst_readdatavalid), W'(1));
      cyc();
    end
    #1;
    check("burst4_done_wait", W'(o_inst_waitrequest), W'(0));
    check("burst4_done_valid", W'(o_inst_readdatavalid), W'(0));
    cyc();

    data_wr(A'((1 << A) - 1), W'(32'hFF00FF));
    inst_q.push_back(W'(32'hFF00FF));
    inst_q.push_back(W'(32'h10));
    inst_rd(A'((1 << A) - 1), W'(2));
    burst_len("wrap_len", 2);

    i_inst_read = 1'b1; i_inst_addr = A'(1); i_inst_burstcount = W'(1);
    i_data_read = 1'b1; i_data_addr = A'(3);
    #1;
    check("prio_data_wait", W'(o_data_waitrequest), W'(0));
    check("prio_inst_wait", W'(o_inst_waitrequest), W'(1));
    data_q.push_back(W'(32'h13));
    cyc();
    i_data_read = 1'b0;
    check("prio_data_first", W'(o_data_readdatavalid), W'(1));
    check("prio_inst_not_yet", W'(o_inst_readdatavalid), W'(0));
    #1;
    check("prio_inst_accept", W'(o_inst_waitrequest), W'(0));
    inst_q.push_back(W'(32'h11));
    cyc();
    i_inst_read = 1'b0;
    check("prio_inst_beat", W'(o_inst_readdatavalid), W'(1));
    burst_len("prio_len", 1);

    for (int i = 0; i < 3; i++) inst_q.push_back(W'(32'h10 + i));
    inst_rd(A'(0), W'(3));
    data_rd(A'(2), W'(32'h12), w);
    check("holdoff_waits", W'(w), W'(3));
    cyc();

    for (int i = 4; i < 8; i++) data_wr(A'(i), W'(32'h10 + i));
    inst_q.push_back(W'(32'h12));
    inst_rd(A'(2), W'(0));
    burst_len("len0", 1);
    for (int i = 0; i < 8; i++) inst_q.push_back(W'(32'h10 + i));
    inst_rd(A'(0), W'(20));
    burst_len("len20", 8);

    inst_q.push_back(W'(32'h10));
    inst_q.push_back(W'(32'h11));
    inst_rd(A'(0), W'(8));
    cyc();
    #5;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_abort_valid", W'(o_inst_readdatavalid), W'(0));
    #5;
    rst = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      #1;
      check("post_rst_valid", W'(o_inst_readdatavalid), W'(0));
      check("post_rst_idle", W'(o_inst_waitrequest), W'(0));
      cyc();
    end
    data_rd(A'(9), W'(32'h55), w);
`endif

    repeat (4) cyc();
    check("inst_q_empty", W'(inst_q.size()), W'(0));
    check("data_q_empty", W'(data_q.size()), W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter P_ADDR_BITS, default `MEM_ADDR_BITS`; the word-address width and the memory depth exponent (depth = 2^P_ADDR_BITS words).
REQ-002 SHALL have parameter P_MAX_BURST, default 8; the largest instruction burst length accepted.
REQ-003 SHALL have parameter P_STALL_CYCLES, default 2; the number of wait cycles per command, used only under MEM_RESPONDER_STALL_EN.
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 i_inst_read  in  1  instruction burst-read command.
REQ-007 i_inst_addr  in  `MEM_ADDR_BITS`  first word address of the burst.
REQ-008 i_inst_burstcount  in  `WORD_BITS`  burst length in words.
REQ-009 o_inst_waitrequest  out  1  instruction command not accepted this cycle.
REQ-010 o_inst_readdata  out  `WORD_BITS`  instruction burst beat data.
REQ-011 o_inst_readdatavalid  out  1  o_inst_readdata is valid this cycle.
REQ-012 i_data_read / i_data_write  in  1 each  data single-word read/write command.
REQ-013 i_data_addr  in  `MEM_ADDR_BITS`  data word address; i_data_writedata  in  `WORD_BITS`  data to write.
REQ-014 o_data_waitrequest  out  1  data command not accepted this cycle.
REQ-015 o_data_readdata  out  `WORD_BITS`  read data; o_data_readdatavalid  out  1  read data valid.

Function
REQ-016 SHALL contain one word-addressed array of 2^P_ADDR_BITS x `WORD_BITS`, shared by both ports; address bits above P_ADDR_BITS are ignored.
REQ-017 A command SHALL be accepted in a cycle where its read or write strobe is high and the matching waitrequest is low.
REQ-018 FSM states SHALL be IDLE and IBURST; reset enters IDLE.
REQ-019 o_inst_waitrequest SHALL be high when (state != IDLE) or (i_data_read | i_data_write).
REQ-020 o_data_waitrequest SHALL be high when state != IDLE; this gives the data port priority over the instruction port when both request in the same IDLE cycle.
REQ-021 An accepted data write SHALL update mem[addr] at that edge; no response beat is produced; the FSM stays in IDLE.
REQ-022 An accepted data read SHALL drive o_data_readdatavalid=1 with mem[addr] exactly 1 cycle later.
REQ-023 Back-to-back data reads SHALL be accepted every cycle.
REQ-024 A read accepted in the cycle after a write to the same address SHALL return the new value.
REQ-025 If a read and a write are asserted together, the write SHALL take effect and the read SHALL be ignored.
REQ-026 An accepted instruction read SHALL latch the address and an effective length L, then move to IBURST; L = burstcount, with 0 treated as 1 and values above P_MAX_BURST clamped to P_MAX_BURST.
REQ-027 In IBURST, one beat SHALL be output per cycle, starting the cycle after acceptance: o_inst_readdatavalid=1 and o_inst_readdata=mem[(addr+k) mod 2^P_ADDR_BITS] for k=0..L-1.
REQ-028 After the last beat, the FSM SHALL return to IDLE; waitrequests fall in the following cycle.
REQ-029 Commands presented while in IBURST SHALL be held off by waitrequest, not dropped.
REQ-030 o_*_readdatavalid SHALL be 0 in every cycle that carries no beat; readdata SHALL hold its last value.

Reset
REQ-031 On rst low: state=IDLE, burst counter=0, o_inst_readdatavalid=0, o_data_readdatavalid=0, o_inst_readdata=0, o_data_readdata=0, stall counter=0.
REQ-032 Reset SHALL NOT clear memory contents.
REQ-033 Reset asserted mid-burst SHALL abort the burst; no further beats are produced after release.

Configuration
REQ-034 With macro MEM_RESPONDER_STALL_EN defined, in IDLE each pending command SHALL see its waitrequest high for P_STALL_CYCLES consecutive cycles before acceptance, counted by a stall counter that reloads after every acceptance.
REQ-035 Without MEM_RESPONDER_STALL_EN, commands SHALL be accepted in the first eligible cycle, per REQ-019/020.

Verification
REQ-036 Write 0xDEADBEEF to addr 5, then read addr 5 on the next cycle -> o_data_readdatavalid the cycle after, o_data_readdata=0xDEADBEEF.
REQ-037 Preload addr 0..3 = 0x10..0x13 via data writes; inst read addr 0, burstcount 4 -> 4 consecutive beats 0x10,0x11,0x12,0x13; waitrequest high for the 4 beat cycles.
REQ-038 Inst read with burstcount 2 at addr 2^P_ADDR_BITS-1 -> beats mem[last], then mem[0].
REQ-039 Inst read and data read in the same IDLE cycle -> data is accepted and its beat is produced first; inst is accepted the following cycle and its burst follows.
REQ-040 burstcount 0 -> 1 beat; burstcount 20 -> 8 beats; rst low after beat 2 of an 8-beat burst -> no beats after release, and the FSM is in IDLE.
REQ-041 With MEM_RESPONDER_STALL_EN defined and P_STALL_CYCLES=2, a held data read -> waitrequest high for 2 cycles, accepted on the 3rd, data one cycle later.
